// File: rtl/dbus_arbiter.sv
// dbus_arbiter
// Two-requester round-robin arbiter for the debug bus (DMI), jtag_TCK domain.
// One transaction is outstanding at a time. The DM response is held for the
// owning requester until it accepts it. An optional watchdog answers with an
// error response when the DM stays silent.
//
// Ports:
//   jtag_TCK, jtag_TRST          clock, async active-high reset
//   rN_req_valid/ready/bits      request channel of requester N (N = 0, 1)
//   rN_resp_valid/ready/bits     response channel of requester N
//   dm_req_valid/ready/bits      request channel towards the Debug Module
//   dm_resp_valid/ready/bits     response channel from the Debug Module
module dbus_arbiter #(
  parameter  int DEBUG_DATA_BITS = 34,
  parameter  int DEBUG_ADDR_BITS = 5,
  parameter  int DEBUG_OP_BITS   = 2,
  parameter  int TIMEOUT_CYCLES  = 0,
  localparam int REQ_BITS  = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS,
  localparam int RESP_BITS = DEBUG_OP_BITS + DEBUG_DATA_BITS
) (
  input  logic                 jtag_TCK,
  input  logic                 jtag_TRST,
  input  logic                 r0_req_valid,
  output logic                 r0_req_ready,
  input  logic [REQ_BITS-1:0]  r0_req_bits,
  output logic                 r0_resp_valid,
  input  logic                 r0_resp_ready,
  output logic [RESP_BITS-1:0] r0_resp_bits,
  input  logic                 r1_req_valid,
  output logic                 r1_req_ready,
  input  logic [REQ_BITS-1:0]  r1_req_bits,
  output logic                 r1_resp_valid,
  input  logic                 r1_resp_ready,
  output logic [RESP_BITS-1:0] r1_resp_bits,
  output logic                 dm_req_valid,
  input  logic                 dm_req_ready,
  output logic [REQ_BITS-1:0]  dm_req_bits,
  input  logic                 dm_resp_valid,
  output logic                 dm_resp_ready,
  input  logic [RESP_BITS-1:0] dm_resp_bits
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [DEBUG_OP_BITS-1:0] OP_ERR = DEBUG_OP_BITS'(2'b10);
  localparam logic [RESP_BITS-1:0] ERR_RESP = {{DEBUG_DATA_BITS{1'b0}}, OP_ERR};
  // Last watchdog count value; only meaningful when the watchdog is enabled.
  localparam logic [31:0] TMO_LAST =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t               state_r;
  logic                 owner_r;
  logic                 last_r;
  logic                 stale_r;
  logic [REQ_BITS-1:0]  req_q_r;
  logic [RESP_BITS-1:0] resp_q_r;
  logic [31:0]          tmo_cnt_r;
  logic                 grant0_s;
  logic                 grant1_s;
  logic                 owner_ready_s;

  // Round-robin grant decode in IDLE; a tie goes to the requester not served last.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_r == IDLE) && !jtag_TRST) begin
      if (r0_req_valid && r1_req_valid) begin
        grant0_s = last_r;
        grant1_s = ~last_r;
      end else begin
        grant0_s = r0_req_valid;
        grant1_s = r1_req_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Response acceptance from whichever requester owns the transaction.
  always_comb begin
    owner_ready_s = 1'b0;
    if (owner_r) begin
      owner_ready_s = r1_resp_ready;
    end else begin
      owner_ready_s = r0_resp_ready;
    end
  end

  assign r0_req_ready  = grant0_s;
  assign r1_req_ready  = grant1_s;
  assign dm_req_valid  = (state_r == REQ);
  assign dm_req_bits   = req_q_r;
  // Outside WAIT the DM port only opens to swallow a response that arrives after a timeout.
  assign dm_resp_ready = (state_r == WAIT) || stale_r;
  assign r0_resp_valid = (state_r == RESP) && !owner_r;
  assign r1_resp_valid = (state_r == RESP) && owner_r;
  assign r0_resp_bits  = resp_q_r;
  assign r1_resp_bits  = resp_q_r;

  // Transaction FSM, watchdog and stale-response bookkeeping.
  always_ff @(posedge jtag_TCK or posedge jtag_TRST) begin
    if (jtag_TRST) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      stale_r   <= 1'b0;
      req_q_r   <= '0;
      resp_q_r  <= '0;
      tmo_cnt_r <= 32'd0;
    end else begin
      // A late response consumed outside WAIT retires the stale marker.
      if ((state_r != WAIT) && stale_r && dm_resp_valid) begin
        stale_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            req_q_r <= grant1_s ? r1_req_bits : r0_req_bits;
            owner_r <= grant1_s;
            last_r  <= grant1_s;
            state_r <= REQ;
          end
        end
        REQ: begin
          if (dm_req_ready) begin
            tmo_cnt_r <= 32'd0;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (dm_resp_valid) begin
            if (stale_r) begin
              // Answer to an already timed-out request: drop it and restart the watchdog.
              stale_r   <= 1'b0;
              tmo_cnt_r <= 32'd0;
            end else begin
              resp_q_r <= dm_resp_bits;
              state_r  <= RESP;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (tmo_cnt_r == TMO_LAST) begin
              resp_q_r <= ERR_RESP;
              stale_r  <= 1'b1;
              state_r  <= RESP;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + 32'd1;
            end
          end
        end
        RESP: begin
          if (owner_ready_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
